// File: rtl/dac_spi_rx_if.sv
// Receive-side handshake bundle of the DAC serial receiver: frame payload,
// request/acknowledge pair and the two status pulses.
interface dac_spi_rx_if;
  logic [15:0] rx_data;
  logic [7:0]  rx_ctrl;
  logic        rx_rq;
  logic        rx_ack;
  logic        overrun;
  logic        frame_err;

  modport master (output rx_data, rx_ctrl, rx_rq, overrun, frame_err, input rx_ack);
  modport slave  (input rx_data, rx_ctrl, rx_rq, overrun, frame_err, output rx_ack);
endinterface

// File: rtl/dac_spi_rx.sv
// DAC 3-wire link receiver: oversamples sdata/bclk/nsync on clock_in,
// shifts MSB-first frames on bclk falls and hands completed frames to the
// consumer through rx_rq/rx_ack.
module dac_spi_rx #(
  parameter int FRAME_BITS  = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clock_in,
  input  logic         reset,
  input  logic         sdata,
  input  logic         bclk,
  input  logic         nsync,
  dac_spi_rx_if.master rx
);
  localparam int            CW       = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  logic [1:0]             rst_pipe;
  logic                   rst_n;
  logic [SYNC_STAGES-1:0] bclk_sync, nsync_sync, sdata_sync, warm_pipe;
  logic                   bclk_d, bclk_s, nsync_s, sdata_s, warm, fall;
  logic                   armed;
  state_t                 state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [FRAME_BITS-1:0]  shift, shift_n;
  logic                   commit_q, commit_n, err_q, err_n;
  logic [15:0]            data_q;
  logic [7:0]             ctrl_q;
  logic                   rq_q, ovr_q;

  // Reset asserts immediately, releases two clocks later to avoid a
  // metastable release against clock_in.
  always_ff @(posedge clock_in or negedge reset)
    if (!reset) rst_pipe <= '0;
    else        rst_pipe <= {rst_pipe[0], 1'b1};

  assign rst_n = rst_pipe[1];

  // Equal-depth synchronizers keep the three lines aligned; warm_pipe marks
  // when the chain holds real line samples rather than its reset pattern.
  always_ff @(posedge clock_in or negedge rst_n)
    if (!rst_n) begin
      bclk_sync  <= '0;
      nsync_sync <= '1;
      sdata_sync <= '0;
      warm_pipe  <= '0;
      bclk_d     <= 1'b0;
    end else begin
      bclk_sync  <= {bclk_sync[SYNC_STAGES-2:0], bclk};
      nsync_sync <= {nsync_sync[SYNC_STAGES-2:0], nsync};
      sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], sdata};
      warm_pipe  <= {warm_pipe[SYNC_STAGES-2:0], 1'b1};
      bclk_d     <= bclk_sync[SYNC_STAGES-1];
    end

  assign bclk_s  = bclk_sync[SYNC_STAGES-1];
  assign nsync_s = nsync_sync[SYNC_STAGES-1];
  assign sdata_s = sdata_sync[SYNC_STAGES-1];
  assign warm    = warm_pipe[SYNC_STAGES-1];
  assign fall    = bclk_d & ~bclk_s;

  // A frame already running at reset release must not be picked up halfway:
  // require a genuine nsync-high sample before the first frame start.
  always_ff @(posedge clock_in or negedge rst_n)
    if (!rst_n)                armed <= 1'b0;
    else if (warm && nsync_s)  armed <= 1'b1;

  // Frame FSM state, bit counter, shift register and event strobes.
  always_ff @(posedge clock_in or negedge rst_n)
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      shift    <= '0;
      commit_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      shift    <= shift_n;
      commit_q <= commit_n;
      err_q    <= err_n;
    end

  // Next-state: nsync high takes priority over a coincident bclk fall.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    shift_n  = shift;
    commit_n = 1'b0;
    err_n    = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (armed && !nsync_s) state_n = S_SHIFT;
      end
      S_SHIFT: begin
        if (nsync_s) begin
          state_n = S_IDLE;
          err_n   = (cnt != '0);
          cnt_n   = '0;
          shift_n = '0;
        end else if (fall) begin
          shift_n = {shift[FRAME_BITS-2:0], sdata_s};
          cnt_n   = cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            state_n  = S_DONE;
            commit_n = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (nsync_s) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Output holding register and handshake; a commit beats a same-cycle ack.
  always_ff @(posedge clock_in or negedge rst_n)
    if (!rst_n) begin
      data_q <= '0;
      ctrl_q <= '0;
      rq_q   <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      ovr_q <= commit_q & rq_q & ~rx.rx_ack;
      if (commit_q) begin
        data_q <= shift[15:0];
        ctrl_q <= shift[FRAME_BITS-1:16];
        rq_q   <= 1'b1;
      end else if (rx.rx_ack) begin
        rq_q   <= 1'b0;
      end
    end

  assign rx.rx_data   = data_q;
  assign rx.rx_ctrl   = ctrl_q;
  assign rx.rx_rq     = rq_q;
  assign rx.overrun   = ovr_q;
  assign rx.frame_err = err_q;
endmodule

// File: tb/tb_dac_spi_rx.sv
// Bench for dac_spi_rx: directed frames; a frame-level model schedules the
// expected commit / error events from the stimulus, and a per-cycle compare
// process checks every output against it.
module tb_dac_spi_rx;
  logic clock_in = 1'b0;
  logic reset    = 1'b0;
  logic sdata    = 1'b0;
  logic bclk     = 1'b0;
  logic nsync    = 1'b1;

  dac_spi_rx_if rxif();

  dac_spi_rx dut (
    .clock_in (clock_in),
    .reset    (reset),
    .sdata    (sdata),
    .bclk     (bclk),
    .nsync    (nsync),
    .rx       (rxif)
  );

  always #5 clock_in = ~clock_in;

  int   total = 0, bad = 0, cyc = 0, ovr_cnt = 0, err_cnt = 0;
  bit   chk_en = 1'b0;

  // Model state and event schedule (keyed by clock index)
  logic        exp_rq = 1'b0, exp_ovr = 1'b0, exp_err = 1'b0;
  logic [15:0] exp_data = '0;
  logic [7:0]  exp_ctrl = '0;
  logic [23:0] commit_at [int];
  bit          err_at    [int];

  // Stimulus-side frame window bookkeeping
  int          win_falls = 0;
  bit          win_valid = 1'b0;
  logic [23:0] win_acc   = '0;

  always @(posedge clock_in) cyc <= cyc + 1;

  // Model: outputs change only on scheduled frame events, acks and reset.
  always @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      exp_rq   <= 1'b0;
      exp_data <= '0;
      exp_ctrl <= '0;
      exp_ovr  <= 1'b0;
      exp_err  <= 1'b0;
      commit_at.delete();
      err_at.delete();
    end else begin
      exp_err <= err_at.exists(cyc);
      exp_ovr <= 1'b0;
      if (commit_at.exists(cyc)) begin
        exp_ovr  <= exp_rq && !rxif.rx_ack;
        exp_rq   <= 1'b1;
        exp_data <= commit_at[cyc][15:0];
        exp_ctrl <= commit_at[cyc][23:16];
      end else if (rxif.rx_ack) begin
        exp_rq <= 1'b0;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  always begin
    @(negedge clock_in);
    if (chk_en) begin
      if (rxif.overrun === 1'b1)   ovr_cnt++;
      if (rxif.frame_err === 1'b1) err_cnt++;
      check("cyc_rq",   {31'd0, rxif.rx_rq},     {31'd0, exp_rq});
      check("cyc_data", {16'd0, rxif.rx_data},   {16'd0, exp_data});
      check("cyc_ctrl", {24'd0, rxif.rx_ctrl},   {24'd0, exp_ctrl});
      check("cyc_ovr",  {31'd0, rxif.overrun},   {31'd0, exp_ovr});
      check("cyc_err",  {31'd0, rxif.frame_err}, {31'd0, exp_err});
    end
  end

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic start_frame();
    nsync     = 1'b0;
    win_valid = 1'b1;
    win_falls = 0;
    win_acc   = '0;
    tick(); tick();
  endtask

  // 4 clocks per bit: 3 high, 1 low. A 24th fall in a live window commits
  // 4 edges later; cyc read here is already one past the driving edge.
  task automatic send_bits(input logic [23:0] val, input int n);
    for (int i = 0; i < n; i++) begin
      logic b;
      b     = (i < 24) ? val[23-i] : 1'b1;
      sdata = b;
      bclk  = 1'b1;
      repeat (3) tick();
      bclk = 1'b0;
      win_falls++;
      if (win_falls <= 24) win_acc = {win_acc[22:0], b};
      if (win_valid && win_falls == 24) commit_at[cyc + 3] = win_acc;
      tick();
    end
  endtask

  // nsync rise after 1..23 bits errors 3 edges later
  task automatic end_frame();
    nsync = 1'b1;
    if (win_valid && win_falls >= 1 && win_falls <= 23) err_at[cyc + 2] = 1'b1;
    win_valid = 1'b0;
    sdata     = 1'b0;
    repeat (4) tick();
  endtask

  task automatic pulse_ack();
    rxif.rx_ack = 1'b1;
    tick();
    rxif.rx_ack = 1'b0;
    tick();
  endtask

  initial begin
    rxif.rx_ack = 1'b0;
    repeat (3) tick();
    chk_en = 1'b1;
    check("rst_rq",   {31'd0, rxif.rx_rq},     32'd0);
    check("rst_data", {16'd0, rxif.rx_data},   32'd0);
    check("rst_ctrl", {24'd0, rxif.rx_ctrl},   32'd0);
    check("rst_err",  {31'd0, rxif.frame_err}, 32'd0);
    reset = 1'b1;
    repeat (6) tick();

    // Single frame, latency and ack
    start_frame();
    send_bits(24'h00ABCD, 24);
    tick(); tick();
    check("t1_lat_early", {31'd0, rxif.rx_rq}, 32'd0);
    tick();
    check("t1_lat_rq",   {31'd0, rxif.rx_rq}, 32'd1);
    check("t1_data",     {16'd0, rxif.rx_data}, 32'h0000ABCD);
    check("t1_ctrl",     {24'd0, rxif.rx_ctrl}, 32'h00);
    end_frame();
    rxif.rx_ack = 1'b1;
    tick();
    rxif.rx_ack = 1'b0;
    check("t1_ack_rq",   {31'd0, rxif.rx_rq}, 32'd0);
    check("t1_ack_data", {16'd0, rxif.rx_data}, 32'h0000ABCD);
    check("t1_no_pulse", ovr_cnt + err_cnt, 32'd0);
    tick();

    // Overrun: two frames without ack
    start_frame();
    send_bits(24'h031234, 24);
    repeat (3) tick();
    check("t2_data1", {16'd0, rxif.rx_data}, 32'h00001234);
    check("t2_ctrl1", {24'd0, rxif.rx_ctrl}, 32'h03);
    end_frame();
    start_frame();
    send_bits(24'h005678, 24);
    repeat (3) tick();
    check("t2_data2", {16'd0, rxif.rx_data}, 32'h00005678);
    check("t2_ctrl2", {24'd0, rxif.rx_ctrl}, 32'h00);
    check("t2_rq",    {31'd0, rxif.rx_rq},   32'd1);
    end_frame();
    check("t2_ovr_cnt", ovr_cnt, 32'd1);

    // Short frame error then a clean frame
    pulse_ack();
    start_frame();
    send_bits(24'h123456, 10);
    end_frame();
    check("t3_err_cnt", err_cnt, 32'd1);
    check("t3_rq",      {31'd0, rxif.rx_rq}, 32'd0);
    start_frame();
    send_bits(24'h00FFFF, 24);
    repeat (3) tick();
    check("t3_data", {16'd0, rxif.rx_data}, 32'h0000FFFF);
    end_frame();

    // 30 falls in one window: only the first 24 count
    pulse_ack();
    start_frame();
    send_bits(24'h00A5A5, 30);
    end_frame();
    check("t4_data",    {16'd0, rxif.rx_data}, 32'h0000A5A5);
    check("t4_rq",      {31'd0, rxif.rx_rq},   32'd1);
    check("t4_err_cnt", err_cnt, 32'd1);

    // Reset mid-frame, released while nsync is still low
    start_frame();
    send_bits(24'h7E5A3C, 12);
    reset     = 1'b0;
    win_valid = 1'b0;
    #1;
    check("t5_rst_rq",   {31'd0, rxif.rx_rq},   32'd0);
    check("t5_rst_data", {16'd0, rxif.rx_data}, 32'd0);
    check("t5_rst_ctrl", {24'd0, rxif.rx_ctrl}, 32'd0);
    repeat (3) tick();
    reset = 1'b1;
    send_bits(24'hA3C000, 12);
    end_frame();
    check("t5_nocap_rq", {31'd0, rxif.rx_rq}, 32'd0);
    check("t5_err_cnt",  err_cnt, 32'd1);
    start_frame();
    send_bits(24'h000001, 24);
    repeat (3) tick();
    check("t5_data", {16'd0, rxif.rx_data}, 32'h00000001);
    check("t5_rq",   {31'd0, rxif.rx_rq},   32'd1);
    end_frame();

    // Ack coincident with a commit while rx_rq is already high
    start_frame();
    send_bits(24'h00BEEF, 24);
    tick(); tick();
    rxif.rx_ack = 1'b1;
    tick();
    rxif.rx_ack = 1'b0;
    check("t6_rq",   {31'd0, rxif.rx_rq},   32'd1);
    check("t6_data", {16'd0, rxif.rx_data}, 32'h0000BEEF);
    tick();
    check("t6_rq_hold", {31'd0, rxif.rx_rq}, 32'd1);
    end_frame();
    check("t6_ovr_cnt", ovr_cnt, 32'd1);

    repeat (4) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
